// File: rtl/rv_decode_stage_if.sv
// Bundles the decode stage's fetch-side handshake, write-back port and
// decoded output bus. The master side is whoever feeds and drains the stage.
interface rv_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_inst, in_pc, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_imm, out_rs1_val, out_rs2_val, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_imm, out_rs1_val, out_rs2_val, out_illegal
    );
endinterface

// File: rtl/rv_decode_stage.sv
// RISC-V decode stage: valid/ready input, field + immediate decode, integrated
// register file with optional write-back bypass, single registered output slot.
module rv_decode_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    rv_decode_stage_if.slave bus
);
    localparam int RIDX = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic            illegal;
    } dec_t;

    logic [XLEN-1:0] regs [NUM_REGS];
    dec_t            dec_d;
    dec_t            dec_q;
    logic            held;
    logic            accept;
    logic            wb_ok;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] rs1_rd;
    logic [XLEN-1:0] rs2_rd;
    logic            illegal;

    wire [31:0] inst   = bus.in_inst;
    wire [6:0]  opcode = inst[6:0];
    wire [2:0]  funct3 = inst[14:12];
    wire [6:0]  funct7 = inst[31:25];
    wire [4:0]  f_rd   = inst[11:7];
    wire [4:0]  f_rs1  = inst[19:15];
    wire [4:0]  f_rs2  = inst[24:20];

    // Register indices above the implemented count (RV32E) do not exist.
    function automatic logic idx_ok(input logic [4:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    // Read port: x0 and nonexistent registers read zero; the write-back
    // value wins over the array when bypass is enabled.
    function automatic logic [XLEN-1:0] rd_port(input logic [4:0] idx);
        logic [XLEN-1:0] v;
        v = '0;
        if (idx != 5'd0 && idx_ok(idx)) begin
            if (BYPASS != 0 && wb_ok && bus.wb_rd == idx) v = bus.wb_data;
            else                                          v = regs[idx[RIDX-1:0]];
        end
        return v;
    endfunction

    assign wb_ok    = bus.wb_en && bus.wb_rd != 5'd0 && idx_ok(bus.wb_rd);
    assign bus.in_ready = !rst && !bus.flush && (!held || bus.out_ready);
    assign accept   = bus.in_valid && bus.in_ready;

    // Operand reads for the instruction being offered.
    always_comb begin
        rs1_rd = rd_port(f_rs1);
        rs2_rd = rd_port(f_rs2);
    end

    // Immediate assembly and legality check, both keyed on the opcode.
    always_comb begin
        logic use_rd;
        logic use_rs1;
        logic use_rs2;
        logic known;
        logic f7_bad;
        imm32   = 32'd0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        known   = 1'b1;
        f7_bad  = 1'b0;
        case (opcode)
            OPC_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                imm32   = {{20{inst[31]}}, inst[31:20]};
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_FENCE: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32   = {inst[31:12], 12'd0};
                use_rd  = 1'b1;
            end
            OPC_JAL: begin
                imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                use_rd  = 1'b1;
            end
            OPC_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (funct7 == 7'b0100000)
                    f7_bad = !(funct3 == 3'b000 || funct3 == 3'b101);
                else
                    f7_bad = (funct7 != 7'b0000000);
            end
            default: known = 1'b0;
        endcase
        illegal = (inst[1:0] != 2'b11) || !known || f7_bad
                || (use_rd  && !idx_ok(f_rd))
                || (use_rs1 && !idx_ok(f_rs1))
                || (use_rs2 && !idx_ok(f_rs2));
    end

    // Widen the 32-bit immediate to the datapath by sign extension.
    generate
        if (XLEN > 32) begin : g_ext
            assign imm_x = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_noext
            assign imm_x = imm32[XLEN-1:0];
        end
    endgenerate

    // Next output-slot contents when an instruction is accepted.
    always_comb begin
        dec_d         = '0;
        dec_d.pc      = bus.in_pc;
        dec_d.opcode  = opcode;
        dec_d.funct3  = funct3;
        dec_d.funct7  = funct7;
        dec_d.rd      = f_rd;
        dec_d.rs1     = f_rs1;
        dec_d.rs2     = f_rs2;
        dec_d.imm     = imm_x;
        dec_d.rs1_val = rs1_rd;
        dec_d.rs2_val = rs2_rd;
        dec_d.illegal = illegal;
    end

    // Register file: reset clears everything; write-back continues during flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_ok) begin
            regs[bus.wb_rd[RIDX-1:0]] <= bus.wb_data;
        end
    end

    // Output slot: flush drops it, accept loads it, a drain empties it, and a
    // stalled slot tracks write-backs to its source registers so operands
    // never go stale while execute is blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            held  <= 1'b0;
            dec_q <= '0;
        end else if (bus.flush) begin
            held  <= 1'b0;
        end else if (accept) begin
            held  <= 1'b1;
            dec_q <= dec_d;
        end else if (held && bus.out_ready) begin
            held  <= 1'b0;
        end else if (held && wb_ok) begin
            if (bus.wb_rd == dec_q.rs1) dec_q.rs1_val <= bus.wb_data;
            if (bus.wb_rd == dec_q.rs2) dec_q.rs2_val <= bus.wb_data;
        end
    end

    assign bus.out_valid   = held;
    assign bus.out_pc      = dec_q.pc;
    assign bus.out_opcode  = dec_q.opcode;
    assign bus.out_funct3  = dec_q.funct3;
    assign bus.out_funct7  = dec_q.funct7;
    assign bus.out_rd      = dec_q.rd;
    assign bus.out_rs1     = dec_q.rs1;
    assign bus.out_rs2     = dec_q.rs2;
    assign bus.out_imm     = dec_q.imm;
    assign bus.out_rs1_val = dec_q.rs1_val;
    assign bus.out_rs2_val = dec_q.rs2_val;
    assign bus.out_illegal = dec_q.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: a 32-bit/32-reg/bypass instance checked every
// cycle against a behavioural model, plus a 64-bit/16-reg/no-bypass instance
// exercised with directed sequences.
module tb_rv_decode_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    rv_decode_stage_if #(.XLEN(32)) ifa ();
    rv_decode_stage_if #(.XLEN(64)) ifb ();

    rv_decode_stage #(.XLEN(32), .NUM_REGS(32), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa.slave));
    rv_decode_stage #(.XLEN(64), .NUM_REGS(16), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model for dut_a ----------------
    logic [31:0] m_regs [32];
    bit          m_valid = 1'b0;
    bit          m_fresh = 1'b0;
    logic [31:0] m_inst, m_pc, m_r1, m_r2;

    // Immediate value computed arithmetically from the format's bit weights.
    function automatic logic [31:0] m_imm(input logic [31:0] i);
        longint sg;
        longint v;
        sg = i[31] ? -1 : 0;
        v  = 0;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: v = sg * 2048 + longint'(i[30:20]);
            7'h23: v = sg * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:7]);
            7'h63: v = sg * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                       + longint'(i[11:8]) * 2;
            7'h37, 7'h17: v = sg * (longint'(1) << 31) + longint'(i[30:12]) * 4096;
            7'h6F: v = sg * (longint'(1) << 20) + longint'(i[19:12]) * 4096
                       + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    function automatic bit m_ill(input logic [31:0] i, input int nr);
        bit ur, u1, u2, bad;
        ur = 0; u1 = 0; u2 = 0;
        bad = (i[1:0] != 2'b11);
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin ur = 1; u1 = 1; end
            7'h23, 7'h63: begin u1 = 1; u2 = 1; end
            7'h37, 7'h17, 7'h6F: ur = 1;
            7'h33: begin
                ur = 1; u1 = 1; u2 = 1;
                if (i[31:25] == 7'h20) begin
                    if (!(i[14:12] == 3'd0 || i[14:12] == 3'd5)) bad = 1;
                end else if (i[31:25] != 7'h00) bad = 1;
            end
            default: bad = 1;
        endcase
        if (ur && int'(i[11:7])  >= nr) bad = 1;
        if (u1 && int'(i[19:15]) >= nr) bad = 1;
        if (u2 && int'(i[24:20]) >= nr) bad = 1;
        return bad;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (ifa.wb_en && ifa.wb_rd == idx) return ifa.wb_data;
        return m_regs[idx];
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 12))
            0: i[6:0] = 7'h13;  1: i[6:0] = 7'h03;  2: i[6:0] = 7'h67;
            3: i[6:0] = 7'h73;  4: i[6:0] = 7'h0F;  5: i[6:0] = 7'h23;
            6: i[6:0] = 7'h63;  7: i[6:0] = 7'h37;  8: i[6:0] = 7'h17;
            9: i[6:0] = 7'h6F;  10, 11: i[6:0] = 7'h33;
            default: ;
        endcase
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        if (i[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0, 1: i[31:25] = 7'h00;
                2: i[31:25] = 7'h20;
                default: i[31:25] = 7'h01;
            endcase
        end
        return i;
    endfunction

    task automatic drive_a(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                           input bit ordy, input bit we, input logic [4:0] wrd,
                           input logic [31:0] wd, input bit fl);
        ifa.in_valid = v;  ifa.in_inst = inst; ifa.in_pc = pc; ifa.out_ready = ordy;
        ifa.wb_en = we;    ifa.wb_rd = wrd;    ifa.wb_data = wd; ifa.flush = fl;
    endtask

    // One clock of dut_a: check in_ready, step the model, check outputs.
    task automatic tick_a();
        bit rdy, acc, wok;
        logic [31:0] r1, r2;
        @(negedge clk);
        rdy = !rst_a && !ifa.flush && (!m_valid || ifa.out_ready);
        chk("in_ready", 192'(ifa.in_ready), 192'(rdy));
        acc = ifa.in_valid && rdy;
        wok = ifa.wb_en && ifa.wb_rd != 0;
        r1  = m_read(ifa.in_inst[19:15]);
        r2  = m_read(ifa.in_inst[24:20]);
        if (rst_a) begin
            foreach (m_regs[k]) m_regs[k] = 32'd0;
            m_valid = 0; m_fresh = 1;
            m_inst = 0; m_pc = 0; m_r1 = 0; m_r2 = 0;
        end else begin
            if (ifa.flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_fresh = 0;
                m_inst = ifa.in_inst; m_pc = ifa.in_pc; m_r1 = r1; m_r2 = r2;
            end else if (m_valid && ifa.out_ready) m_valid = 0;
            else if (m_valid && wok) begin
                if (ifa.wb_rd == m_inst[19:15]) m_r1 = ifa.wb_data;
                if (ifa.wb_rd == m_inst[24:20]) m_r2 = ifa.wb_data;
            end
            if (wok) m_regs[ifa.wb_rd] = ifa.wb_data;
        end
        @(posedge clk); #1;
        chk("out_valid", 192'(ifa.out_valid), 192'(m_valid));
        if (m_valid || m_fresh) begin
            logic [191:0] act, exp;
            act = 192'({ifa.out_pc, ifa.out_opcode, ifa.out_funct3, ifa.out_funct7,
                        ifa.out_rd, ifa.out_rs1, ifa.out_rs2, ifa.out_imm,
                        ifa.out_rs1_val, ifa.out_rs2_val, ifa.out_illegal});
            if (m_fresh && !m_valid) exp = '0;
            else exp = 192'({m_pc, m_inst[6:0], m_inst[14:12], m_inst[31:25],
                             m_inst[11:7], m_inst[19:15], m_inst[24:20], m_imm(m_inst),
                             m_r1, m_r2, m_ill(m_inst, 32)});
            chk("out_fields", act, exp);
        end
    endtask

    task automatic drive_b(input bit v, input logic [31:0] inst,
                           input bit we, input logic [4:0] wrd, input logic [63:0] wd);
        ifb.in_valid = v; ifb.in_inst = inst; ifb.in_pc = 64'h1000;
        ifb.wb_en = we;   ifb.wb_rd = wrd;    ifb.wb_data = wd;
        ifb.out_ready = 1'b1; ifb.flush = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vt [13];

    initial begin
        vt[0]  = '{32'hFFF28313, 32'hFFFFFFFF, 1'b0};  // addi x6,x5,-1
        vt[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 1'b0};  // beq back by 4
        vt[2]  = '{32'h001000EF, 32'h00000800, 1'b0};  // jal +0x800
        vt[3]  = '{32'h800001B7, 32'h80000000, 1'b0};  // lui
        vt[4]  = '{32'h12345017, 32'h12345000, 1'b0};  // auipc
        vt[5]  = '{32'h00A12223, 32'h00000004, 1'b0};  // sw x10,4(x2)
        vt[6]  = '{32'hFFF2A303, 32'hFFFFFFFF, 1'b0};  // lw x6,-1(x5)
        vt[7]  = '{32'h00000000, 32'h00000000, 1'b1};  // all-zero word
        vt[8]  = '{32'h40001033, 32'h00000000, 1'b1};  // funct7 0100000, funct3 001
        vt[9]  = '{32'h40005033, 32'h00000000, 1'b0};  // sra
        vt[10] = '{32'h02000033, 32'h00000000, 1'b1};  // funct7 0000001
        vt[11] = '{32'h0000000F, 32'h00000000, 1'b0};  // fence
        vt[12] = '{32'h00000011, 32'h00000000, 1'b1};  // low bits 01

        rst_a = 1'b1; rst_b = 1'b1;
        drive_a(0, 0, 0, 1, 0, 0, 0, 0);
        ifb.in_valid = 0; ifb.in_inst = 0; ifb.in_pc = 0; ifb.wb_en = 0;
        ifb.wb_rd = 0; ifb.wb_data = 0; ifb.out_ready = 1; ifb.flush = 0;

        // reset
        tick_a(); tick_a();
        rst_a = 1'b0;
        tick_a();
        chk("in_ready_after_rst", 192'(ifa.in_ready), 192'd1);

        // write x5 then addi x6,x5,-1
        drive_a(0, 0, 0, 1, 1, 5'd5, 32'h12345678, 0); tick_a();
        drive_a(1, 32'hFFF28313, 32'h100, 1, 0, 0, 0, 0); tick_a();
        chk("addi_opcode", 192'(ifa.out_opcode), 192'(7'b0010011));
        chk("addi_rd",     192'(ifa.out_rd), 192'd6);
        chk("addi_rs1",    192'(ifa.out_rs1), 192'd5);
        chk("addi_rs1val", 192'(ifa.out_rs1_val), 192'h12345678);
        chk("addi_imm",    192'(ifa.out_imm), 192'hFFFFFFFF);
        chk("addi_ill",    192'(ifa.out_illegal), 192'd0);

        // same-cycle bypass
        drive_a(1, 32'h00108133, 32'h104, 1, 1, 5'd1, 32'hCAFEF00D, 0); tick_a();
        chk("byp_rs1val", 192'(ifa.out_rs1_val), 192'hCAFEF00D);
        chk("byp_rs2val", 192'(ifa.out_rs2_val), 192'hCAFEF00D);

        // immediates / illegal table
        for (int i = 0; i < 13; i++) begin
            drive_a(1, vt[i].inst, 32'h400 + 32'(i * 4), 1, 0, 0, 0, 0);
            tick_a();
            chk($sformatf("tbl_imm[%0d]", i), 192'(ifa.out_imm), 192'(vt[i].imm));
            chk($sformatf("tbl_ill[%0d]", i), 192'(ifa.out_illegal), 192'(vt[i].ill));
        end

        // backpressure: hold add x2,x1,x1 for 3 cycles, update x1 mid-stall
        drive_a(1, 32'h00108133, 32'h200, 1, 0, 0, 0, 0); tick_a();
        drive_a(1, 32'hFFF28313, 32'h204, 0, 0, 0, 0, 0); tick_a();
        chk("stall_pc1", 192'(ifa.out_pc), 192'h200);
        drive_a(1, 32'hFFF28313, 32'h204, 0, 1, 5'd1, 32'h0BADBEEF, 0); tick_a();
        chk("stall_rs1val", 192'(ifa.out_rs1_val), 192'h0BADBEEF);
        chk("stall_rs2val", 192'(ifa.out_rs2_val), 192'h0BADBEEF);
        drive_a(1, 32'hFFF28313, 32'h204, 0, 0, 0, 0, 0); tick_a();
        chk("stall_pc3", 192'(ifa.out_pc), 192'h200);
        drive_a(1, 32'hFFF28313, 32'h204, 1, 0, 0, 0, 0); tick_a();
        chk("drain_pc", 192'(ifa.out_pc), 192'h204);
        chk("drain_valid", 192'(ifa.out_valid), 192'd1);
        drive_a(0, 0, 0, 1, 0, 0, 0, 0); tick_a();
        chk("no_dup", 192'(ifa.out_valid), 192'd0);

        // flush while holding; write-back still lands during flush
        drive_a(1, 32'h00108133, 32'h300, 1, 0, 0, 0, 0); tick_a();
        drive_a(1, 32'hFFF28313, 32'h304, 0, 1, 5'd7, 32'h00000077, 1); tick_a();
        chk("flush_valid", 192'(ifa.out_valid), 192'd0);
        drive_a(0, 0, 0, 1, 0, 0, 0, 0); tick_a();
        chk("flush_not_consumed", 192'(ifa.out_valid), 192'd0);
        drive_a(1, 32'h00038433, 32'h308, 1, 0, 0, 0, 0); tick_a();
        chk("flush_wb", 192'(ifa.out_rs1_val), 192'h77);

        // reset mid-stall
        drive_a(1, 32'hFFF28313, 32'h500, 0, 0, 0, 0, 0); tick_a();
        rst_a = 1'b1;
        drive_a(1, 32'h00108133, 32'h504, 0, 0, 0, 0, 0); tick_a();
        chk("rst_valid", 192'(ifa.out_valid), 192'd0);
        chk("rst_pc", 192'(ifa.out_pc), 192'd0);
        rst_a = 1'b0;
        drive_a(0, 0, 0, 1, 0, 0, 0, 0); tick_a();
        chk("rst_no_accept", 192'(ifa.out_valid), 192'd0);
        drive_a(1, 32'hFFF28313, 32'h508, 1, 0, 0, 0, 0); tick_a();
        chk("rst_x5", 192'(ifa.out_rs1_val), 192'd0);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            drive_a($urandom_range(0, 99) < 75, rnd_inst(), $urandom,
                    $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 99) < 5);
            tick_a();
        end

        // dut_b: XLEN=64, NUM_REGS=16, BYPASS=0
        @(posedge clk); #1;
        chk("b_rst_ready", 192'(ifb.in_ready), 192'd0);
        chk("b_rst_valid", 192'(ifb.out_valid), 192'd0);
        rst_b = 1'b0;
        drive_b(1, 32'h00108133, 1, 5'd1, 64'hCAFEF00D);
        chk("b_nobyp_rs1", 192'(ifb.out_rs1_val), 192'd0);
        chk("b_nobyp_rs2", 192'(ifb.out_rs2_val), 192'd0);
        chk("b_add_ill",   192'(ifb.out_illegal), 192'd0);
        drive_b(1, 32'h00108133, 0, 0, 0);
        chk("b_next_rs1", 192'(ifb.out_rs1_val), 192'hCAFEF00D);
        chk("b_next_rs2", 192'(ifb.out_rs2_val), 192'hCAFEF00D);
        drive_b(1, 32'h800001B7, 0, 0, 0);
        chk("b_lui_imm", 192'(ifb.out_imm), 192'hFFFFFFFF80000000);
        drive_b(1, 32'h00000813, 1, 5'd16, 64'h55);
        chk("b_x16_ill", 192'(ifb.out_illegal), 192'd1);
        drive_b(1, 32'h00080093, 1, 5'd17, 64'h99);
        chk("b_x16_read", 192'(ifb.out_rs1_val), 192'd0);
        chk("b_x16_src_ill", 192'(ifb.out_illegal), 192'd1);
        drive_b(1, 32'h01108133, 0, 0, 0);
        chk("b_x1_kept", 192'(ifb.out_rs1_val), 192'hCAFEF00D);
        chk("b_x17_read", 192'(ifb.out_rs2_val), 192'd0);
        drive_b(0, 0, 0, 0, 0);
        chk("b_drain", 192'(ifb.out_valid), 192'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
